// File: rtl/zbb_exec_unit.sv
// zbb_exec_unit: two-stage valid/ready pipelined Zbb execute unit (XLEN 32/64).
// Define ZBB_ROTATE_EN to build rol/ror/rori; otherwise those codes report illegal.
module zbb_exec_unit #(
   parameter int XLEN = 32,
   localparam int SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [XLEN-1:0] ex_mem_i,
   input  logic [XLEN-1:0] mem_wb_i,
   input  logic [1:0]      mux1_i,
   input  logic [1:0]      mux2_i,
   input  logic            mux3_i,
   input  logic [4:0]      alu_op_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] res_o,
   output logic            illegal_o
);
   logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, ill_q, ill_d, alu_ill, s1_load, s2_load;
   logic [4:0] op_q, op_d;
   logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d, alu_res, op1_sel, op2_pre, orc, rev;
   logic [SHW:0] clz, ctz, pop;

   assign s2_load = s1_valid_q & (!s2_valid_q | out_ready_i);
   assign in_ready_o = !s1_valid_q | s2_load;
   assign s1_load = in_valid_i & in_ready_o;
   assign op1_sel = mux1_i == 2'b00 ? rs1_i : mux1_i == 2'b01 ? mem_wb_i : mux1_i == 2'b10 ? ex_mem_i : '0;
   assign op2_pre = mux2_i == 2'b00 ? rs2_i : mux2_i == 2'b01 ? mem_wb_i : mux2_i == 2'b10 ? ex_mem_i : '0;
   assign out_valid_o = s2_valid_q;
   assign res_o = res_q;
   assign illegal_o = ill_q;

   always_comb begin
      s1_valid_d = s1_load | (s1_valid_q & !s2_load);
      s2_valid_d = s2_load | (s2_valid_q & !out_ready_i);
      op1_d = s1_load ? op1_sel : op1_q;
      op2_d = s1_load ? (mux3_i ? imm_i : op2_pre) : op2_q;
      op_d = s1_load ? alu_op_i : op_q;
      res_d = s2_load ? alu_res : res_q;
      ill_d = s2_load ? alu_ill : ill_q;
   end

   // Last hit wins: clz keeps the highest set bit, ctz the lowest.
   always_comb begin
      clz = (SHW+1)'(XLEN);
      ctz = (SHW+1)'(XLEN);
      pop = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (op1_q[i]) clz = (SHW+1)'(XLEN-1-i);
         if (op1_q[XLEN-1-i]) ctz = (SHW+1)'(XLEN-1-i);
         pop = pop + (SHW+1)'(op1_q[i]);
      end
      orc = '0;
      rev = '0;
      for (int b = 0; b < XLEN/8; b++) begin
         orc[8*b +: 8] = {8{|op1_q[8*b +: 8]}};
         rev[8*b +: 8] = op1_q[XLEN-8-8*b +: 8];
      end
   end

`ifdef ZBB_ROTATE_EN
   logic [SHW-1:0] sh, shn;
   logic [XLEN-1:0] rol, ror;
   assign sh = op2_q[SHW-1:0];
   assign shn = -sh;
   assign rol = (op1_q << sh) | (op1_q >> shn);
   assign ror = (op1_q >> sh) | (op1_q << shn);
`endif

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op_q)
         5'b00000: alu_res = '0;
         5'b00001: alu_res = XLEN'(clz);
         5'b00010: alu_res = XLEN'(ctz);
         5'b00011: alu_res = XLEN'(pop);
         5'b00100: alu_res = op1_q < op2_q ? op1_q : op2_q;
         5'b00101: alu_res = op1_q > op2_q ? op1_q : op2_q;
         5'b00110: alu_res = {{(XLEN-16){op1_q[15]}}, op1_q[15:0]};
         5'b00111: alu_res = {{(XLEN-8){op1_q[7]}}, op1_q[7:0]};
         5'b01000: alu_res = $signed(op1_q) > $signed(op2_q) ? op1_q : op2_q;
         5'b01001: alu_res = $signed(op1_q) < $signed(op2_q) ? op1_q : op2_q;
         5'b01010: alu_res = {{(XLEN-16){1'b0}}, op1_q[15:0]};
`ifdef ZBB_ROTATE_EN
         5'b01011: alu_res = rol;
         5'b01100: alu_res = ror;
         5'b01101: alu_res = ror;
`endif
         5'b01110: alu_res = orc;
         5'b01111: alu_res = rev;
         5'b10000: alu_res = op1_q & ~op2_q;
         5'b10001: alu_res = op1_q | ~op2_q;
         5'b10010: alu_res = ~(op1_q ^ op2_q);
         default:  alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         op1_q <= '0;
         op2_q <= '0;
         op_q <= '0;
         res_q <= '0;
         ill_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         op1_q <= op1_d;
         op2_q <= op2_d;
         op_q <= op_d;
         res_q <= res_d;
         ill_q <= ill_d;
      end
endmodule

// File: tb/tb_zbb_exec_unit.sv
// tb_zbb_exec_unit: scoreboard bench for zbb_exec_unit (XLEN 32 main instance, XLEN 64 side instance).
module tb_zbb_exec_unit;
   localparam logic [4:0] ZERO = 5'b00000, CLZ = 5'b00001, CTZ = 5'b00010, CPOP = 5'b00011;
   localparam logic [4:0] MINU = 5'b00100, MAXU = 5'b00101, SEXTH = 5'b00110, SEXTB = 5'b00111;
   localparam logic [4:0] MAX = 5'b01000, MIN = 5'b01001, ZEXTH = 5'b01010, ROL = 5'b01011;
   localparam logic [4:0] ROR = 5'b01100, RORI = 5'b01101, ORCB = 5'b01110, REV8 = 5'b01111;
   localparam logic [4:0] ANDN = 5'b10000, ORN = 5'b10001, XNOR = 5'b10010;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] rs1, rs2, imm, exm, mwb;
      logic [1:0]  m1, m2;
      logic        m3;
   } op_t;
   typedef struct packed {
      logic [31:0] res;
      logic        ill;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, illegal, mux3 = 1'b0;
   logic [31:0] rs1 = '0, rs2 = '0, imm = '0, ex_mem = '0, mem_wb = '0, res;
   logic [1:0] mux1 = '0, mux2 = '0;
   logic [4:0] alu_op = '0;
   logic w_in_valid = 1'b0, w_in_ready, w_out_valid, w_illegal;
   logic [63:0] w_rs1 = '0, w_res;
   logic [4:0] w_alu_op = '0;

   int n_assert = 0, n_fail = 0;
   logic acc, xfer, s_ir, s_ov, s_ill;
   logic [31:0] s_res;
   exp_t sb[$];

   always #5 clk = ~clk;

   zbb_exec_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .ex_mem_i(ex_mem), .mem_wb_i(mem_wb),
      .mux1_i(mux1), .mux2_i(mux2), .mux3_i(mux3), .alu_op_i(alu_op),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .illegal_o(illegal)
   );

   zbb_exec_unit #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
      .rs1_i(w_rs1), .rs2_i(64'd0), .imm_i(64'd0), .ex_mem_i(64'd0), .mem_wb_i(64'd0),
      .mux1_i(2'b00), .mux2_i(2'b00), .mux3_i(1'b0), .alu_op_i(w_alu_op),
      .out_valid_o(w_out_valid), .out_ready_i(1'b1), .res_o(w_res), .illegal_o(w_illegal)
   );

   function automatic op_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      op_t o;
      o = '0;
      o.op = op;
      o.rs1 = a;
      o.rs2 = b;
      return o;
   endfunction

   function automatic exp_t ev(input logic [31:0] r, input logic i);
      exp_t e;
      e.res = r;
      e.ill = i;
      return e;
   endfunction

   // One cycle: drive at negedge, snapshot outputs, record accept/transfer for the coming posedge.
   task automatic cycle(input logic v, input op_t o, input logic ordy, input exp_t e);
      @(negedge clk);
      in_valid = v;
      alu_op = o.op;
      rs1 = o.rs1;
      rs2 = o.rs2;
      imm = o.imm;
      ex_mem = o.exm;
      mem_wb = o.mwb;
      mux1 = o.m1;
      mux2 = o.m2;
      mux3 = o.m3;
      out_ready = ordy;
      #1;
      s_ir = in_ready;
      s_ov = out_valid;
      s_res = res;
      s_ill = illegal;
      acc = v & in_ready;
      xfer = out_valid & ordy;
      if (acc) sb.push_back(e);
   endtask

   task automatic test_reset();
      #1;
      n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      n_assert++; if (res !== 32'd0) begin n_fail++; $display("FAIL reset_res got=%h want=0", res); end
      n_assert++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b want=0", illegal); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_single_clz();
      exp_t x;
      cycle(1'b1, mk(CLZ, 32'h0001_0000, 32'd0), 1'b1, ev(32'd15, 1'b0));
      n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL clz_accept got=%b want=1", acc); end
      cycle(1'b0, mk(ZERO, 0, 0), 1'b1, ev(0, 0));
      n_assert++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL clz_latency_early got=%b want=0", s_ov); end
      cycle(1'b0, mk(ZERO, 0, 0), 1'b1, ev(0, 0));
      n_assert++; if (s_ov !== 1'b1) begin n_fail++; $display("FAIL clz_latency got=%b want=1", s_ov); end
      if (xfer && sb.size() != 0) begin
         x = sb.pop_front();
         n_assert++; if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL clz_result got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
      end
      sb.delete();
   endtask

   task automatic test_forwarding();
      op_t o[9];
      exp_t e[9];
      exp_t x;
      o[0] = mk(MAXU, 32'h1111_1111, 32'd5); o[0].m1 = 2'b10; o[0].exm = 32'h8000_0000; e[0] = ev(32'h8000_0000, 0);
      o[1] = o[0]; o[1].op = MAX;  e[1] = ev(32'd5, 0);
      o[2] = o[0]; o[2].op = MINU; e[2] = ev(32'd5, 0);
      o[3] = o[0]; o[3].op = MIN;  e[3] = ev(32'h8000_0000, 0);
      o[4] = mk(ANDN, 32'h1234_5678, 32'hFFFF_FFFF); o[4].m1 = 2'b01; o[4].mwb = 32'hF0F0_FFFF;
      o[4].m3 = 1'b1; o[4].imm = 32'h0000_FFFF; e[4] = ev(32'hF0F0_0000, 0);
      o[5] = mk(ORN, 32'hDEAD_BEEF, 32'h1234_5678); o[5].m1 = 2'b11; o[5].m2 = 2'b10;
      o[5].exm = 32'h0F0F_0F0F; e[5] = ev(32'hF0F0_F0F0, 0);
      o[6] = mk(XNOR, 32'hFFFF_0000, 32'h5555_5555); o[6].m2 = 2'b01; o[6].mwb = 32'h0F0F_0F0F; e[6] = ev(32'h0F0F_F0F0, 0);
      o[7] = mk(MAXU, 32'd3, 32'd100); o[7].m3 = 1'b1; o[7].imm = 32'd7; e[7] = ev(32'd7, 0);
      o[8] = mk(MAXU, 32'd3, 32'd100); o[8].m2 = 2'b11; e[8] = ev(32'd3, 0);
      for (int c = 0; c < 13; c++) begin
         cycle(c < 9, o[c < 9 ? c : 0], 1'b1, e[c < 9 ? c : 0]);
         if (xfer) begin
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL fwd_spurious got=%h want=none", s_res); end
            else begin
               x = sb.pop_front();
               if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL fwd_result got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
            end
         end
      end
      n_assert++; if (sb.size() != 0) begin n_fail++; $display("FAIL fwd_missing got=%0d want=0 pending", sb.size()); end
      sb.delete();
   endtask

   task automatic test_bitops();
      op_t o[16];
      exp_t e[16];
      exp_t x;
      o[0]  = mk(ORCB,  32'h0012_0000, 0); e[0]  = ev(32'h00FF_0000, 0);
      o[1]  = mk(REV8,  32'h0012_0000, 0); e[1]  = ev(32'h0000_1200, 0);
      o[2]  = mk(CTZ,   32'h0001_0000, 0); e[2]  = ev(32'd16, 0);
      o[3]  = mk(CTZ,   32'h0000_0000, 0); e[3]  = ev(32'd32, 0);
      o[4]  = mk(CLZ,   32'h0000_0000, 0); e[4]  = ev(32'd32, 0);
      o[5]  = mk(CLZ,   32'hFFFF_FFFF, 0); e[5]  = ev(32'd0, 0);
      o[6]  = mk(CPOP,  32'hF0F0_0001, 0); e[6]  = ev(32'd9, 0);
      o[7]  = mk(CPOP,  32'hFFFF_FFFF, 0); e[7]  = ev(32'd32, 0);
      o[8]  = mk(SEXTH, 32'h0000_8001, 0); e[8]  = ev(32'hFFFF_8001, 0);
      o[9]  = mk(SEXTB, 32'h0000_0080, 0); e[9]  = ev(32'hFFFF_FF80, 0);
      o[10] = mk(ZEXTH, 32'hFFFF_1234, 0); e[10] = ev(32'h0000_1234, 0);
      o[11] = mk(ZERO,  32'hFFFF_FFFF, 32'h1); e[11] = ev(32'd0, 0);
      o[12] = mk(5'b10011, 32'hFFFF_FFFF, 32'h1); e[12] = ev(32'd0, 1);
      o[13] = mk(5'b11111, 32'hFFFF_FFFF, 32'h1); e[13] = ev(32'd0, 1);
      o[14] = mk(ORCB,  32'h0100_0010, 0); e[14] = ev(32'hFF00_00FF, 0);
      o[15] = mk(CTZ,   32'h8000_0000, 0); e[15] = ev(32'd31, 0);
      for (int c = 0; c < 20; c++) begin
         cycle(c < 16, o[c < 16 ? c : 0], 1'b1, e[c < 16 ? c : 0]);
         if (c < 16) begin
            n_assert++; if (acc !== 1'b1) begin n_fail++; $display("FAIL bit_throughput got=%b want=1 at op %0d", acc, c); end
         end
         if (xfer) begin
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL bit_spurious got=%h want=none", s_res); end
            else begin
               x = sb.pop_front();
               if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL bit_result got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
            end
         end
      end
      n_assert++; if (sb.size() != 0) begin n_fail++; $display("FAIL bit_missing got=%0d want=0 pending", sb.size()); end
      sb.delete();
   endtask

   task automatic test_rotate();
      op_t o[5];
      exp_t e[5];
      exp_t x;
      o[0] = mk(ROL, 32'h8000_0001, 32'd1);
      o[1] = mk(ROR, 32'h8000_0001, 32'd1);
      o[2] = mk(RORI, 32'h1234_5678, 32'd7); o[2].m3 = 1'b1; o[2].imm = 32'd36;
      o[3] = mk(ROL, 32'h1234_5678, 32'd32);
      o[4] = mk(ROR, 32'h1234_5678, 32'd31);
`ifdef ZBB_ROTATE_EN
      e[0] = ev(32'h0000_0003, 0);
      e[1] = ev(32'hC000_0001 & 32'hC000_0000, 0);
      e[2] = ev(32'h8123_4567, 0);
      e[3] = ev(32'h1234_5678, 0);
      e[4] = ev(32'h2468_ACF0, 0);
`else
      for (int i = 0; i < 5; i++) e[i] = ev(32'd0, 1);
`endif
      for (int c = 0; c < 9; c++) begin
         cycle(c < 5, o[c < 5 ? c : 0], 1'b1, e[c < 5 ? c : 0]);
         if (xfer) begin
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL rot_spurious got=%h want=none", s_res); end
            else begin
               x = sb.pop_front();
               if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL rot_result got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
            end
         end
      end
      n_assert++; if (sb.size() != 0) begin n_fail++; $display("FAIL rot_missing got=%0d want=0 pending", sb.size()); end
      sb.delete();
   endtask

   task automatic test_back_to_back();
      op_t o[4];
      exp_t e[4];
      exp_t x;
      int k = 0, got = 0;
      o[0] = mk(CLZ,  32'h0000_0100, 0); e[0] = ev(32'd23, 0);
      o[1] = mk(CPOP, 32'h0000_00FF, 0); e[1] = ev(32'd8, 0);
      o[2] = mk(XNOR, 32'd0, 32'd0);     e[2] = ev(32'hFFFF_FFFF, 0);
      o[3] = mk(ORCB, 32'h0100_0010, 0); e[3] = ev(32'hFF00_00FF, 0);
      for (int c = 0; c < 16; c++) begin
         cycle(k < 4, o[k < 4 ? k : 0], c >= 5, e[k < 4 ? k : 0]);
         if (acc) k++;
         if (c == 1) begin
            n_assert++; if (s_ir !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b want=1", s_ir); end
         end
         if (c >= 2 && c <= 4) begin
            n_assert++; if (s_ir !== 1'b0 || s_ov !== 1'b1) begin n_fail++; $display("FAIL b2b_stall ready/valid got=%b/%b want=0/1", s_ir, s_ov); end
            n_assert++; if (s_res !== 32'd23 || k != 2) begin n_fail++; $display("FAIL b2b_hold got=%h accepts=%0d want=%h accepts=2", s_res, k, 32'd23); end
         end
         if (xfer) begin
            got++;
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_spurious got=%h want=none", s_res); end
            else begin
               x = sb.pop_front();
               if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL b2b_order got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
            end
         end
      end
      n_assert++; if (got != 4 || sb.size() != 0) begin n_fail++; $display("FAIL b2b_count got=%0d want=4", got); end
      sb.delete();
   endtask

   task automatic test_reset_inflight();
      exp_t x;
      int got = 0;
      cycle(1'b1, mk(CPOP, 32'h0000_000F, 0), 1'b1, ev(32'd4, 0));
      cycle(1'b1, mk(CPOP, 32'h0000_00FF, 0), 1'b1, ev(32'd8, 0));
      @(posedge clk);
      #2;
      n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_pre got=%b want=1", out_valid); end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_assert++; if (out_valid !== 1'b0 || res !== 32'd0) begin n_fail++; $display("FAIL rst_async got=%b/%h want=0/0", out_valid, res); end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, mk(CLZ, 32'h0000_0001, 0), 1'b1, ev(32'd31, 0));
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, mk(ZERO, 0, 0), 1'b1, ev(0, 0));
         if (xfer) begin
            got++;
            n_assert++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL rst_spurious got=%h want=none", s_res); end
            else begin
               x = sb.pop_front();
               if (s_res !== x.res || s_ill !== x.ill) begin n_fail++; $display("FAIL rst_after got=%h/%b want=%h/%b", s_res, s_ill, x.res, x.ill); end
            end
         end
      end
      n_assert++; if (got != 1) begin n_fail++; $display("FAIL rst_after_count got=%0d want=1", got); end
      sb.delete();
   endtask

   task automatic test_xlen64();
      logic [63:0] a[3], r[3];
      logic [4:0] op[3];
      a[0] = 64'h0102_0304_0506_0708; op[0] = REV8; r[0] = 64'h0807_0605_0403_0201;
      a[1] = 64'h0;                   op[1] = CLZ;  r[1] = 64'd64;
      a[2] = 64'h8000_0000_0000_0000; op[2] = CTZ;  r[2] = 64'd63;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         w_in_valid = 1'b1;
         w_rs1 = a[i];
         w_alu_op = op[i];
         @(negedge clk);
         w_in_valid = 1'b0;
         for (int t = 0; t < 5 && !w_out_valid; t++) @(negedge clk);
         n_assert++;
         if (w_out_valid !== 1'b1 || w_res !== r[i] || w_illegal !== 1'b0) begin
            n_fail++; $display("FAIL x64_result got=%b/%h want=1/%h", w_out_valid, w_res, r[i]);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_clz();
      test_forwarding();
      test_bitops();
      test_rotate();
      test_back_to_back();
      test_reset_inflight();
      test_xlen64();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
